// File: rtl/rover_pio_in.sv
// rover_pio_in: Avalon-MM input PIO. Synchronizes external inputs, optionally
// debounces them per bit, latches selected edges in a sticky W1C register and
// raises a masked level interrupt.
// Latency: DATA readable 1 cycle after deb changes; deb follows in_port after
// 2 edges (+DEBOUNCE_CYCLES when debouncing). Read data is registered (1 cycle).
// Backpressure: none; the slave always accepts reads and writes immediately.
//
// Ports:
//   clk, reset              system clock, async active-high reset
//   address[1:0]            word select: 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE
//   chipselect, write_n     write strobe = chipselect & ~write_n
//   writedata[31:0]         write data (only [WIDTH-1:0] used)
//   readdata[31:0]          registered read mux, upper bits zero
//   in_port[WIDTH-1:0]      asynchronous external inputs
//   irq                     OR of (edge_capture & irq_mask)

module rover_pio_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic [31:0]      rd_next;

    // Upper writedata bits are intentionally ignored for narrow ports.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wdata = writedata[WIDTH-1:0];
    assign wr_en = chipselect & ~write_n;

    // Two-flop synchronizer, always present.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
            assign deb = sync2;
        end else begin : g_deb
            localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
            logic [15:0]      cnt [WIDTH];
            logic [WIDTH-1:0] deb_q;

            // A bit is accepted only after DEBOUNCE_CYCLES consecutive
            // disagreeing samples; any agreeing sample restarts the count.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    deb_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2[i] != deb_q[i]) begin
                            if (cnt[i] == CNT_LAST) begin
                                deb_q[i] <= sync2[i];
                                cnt[i]   <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + 16'd1;
                            end
                        end else begin
                            cnt[i] <= '0;
                        end
                    end
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    always_comb begin
        edge_event = '0;
        case (EDGE_TYPE)
            0:       edge_event = deb & ~deb_prev;
            1:       edge_event = ~deb & deb_prev;
            default: edge_event = deb ^ deb_prev;
        endcase
    end

    always_comb begin
        rd_next = '0;
        case (address)
            2'd0:    rd_next[WIDTH-1:0] = deb;
            2'd2:    rd_next[WIDTH-1:0] = irq_mask;
            2'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev     <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            deb_prev <= deb;
            readdata <= rd_next;
            if (wr_en && address == 2'd2) begin
                irq_mask <= wdata;
            end
            // A new event on the same edge as a W1C keeps the bit set.
            if (wr_en && address == 2'd3) begin
                edge_capture <= (edge_capture & ~wdata) | edge_event;
            end else begin
                edge_capture <= edge_capture | edge_event;
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_rover_pio_in.sv
// tb_rover_pio_in: drives three rover_pio_in instances (plain rising, 4-cycle
// debounce, any-edge) from a shared bus with directed and random stimulus, and
// compares readdata/irq every cycle against a behavioural model.

module tb_rover_pio_in;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in0 = '0, in1 = '0, in2 = '0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rover_pio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_d0 (
        .clk(clk), .reset(rst), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0));

    rover_pio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_d4 (
        .clk(clk), .reset(rst), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1));

    rover_pio_in #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(rst), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in2), .irq(irq2));

    // Behavioural model: per instance, state as seen after the last edge.
    int         md [3] = '{0, 4, 0};
    int         met[3] = '{0, 0, 2};
    logic [7:0] m_s1[3], m_s2[3], m_deb[3], m_prev[3], m_cap[3], m_mask[3];
    int         m_cnt[3][8];
    logic [31:0] m_rd[3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 3; i++) begin
            m_s1[i] = '0; m_s2[i] = '0; m_deb[i] = '0; m_prev[i] = '0;
            m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
            for (int b = 0; b < 8; b++) m_cnt[i][b] = 0;
        end
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_step();
        logic [7:0] din, dnow, rise, fall, ev, clr;
        bit         wr;
        if (rst) begin
            model_zero();
            return;
        end
        wr = chipselect && !write_n;
        for (int i = 0; i < 3; i++) begin
            din  = (i == 0) ? in0 : (i == 1) ? in1 : in2;
            dnow = (md[i] == 0) ? m_s2[i] : m_deb[i];
            rise = dnow & ~m_prev[i];
            fall = ~dnow & m_prev[i];
            ev   = (met[i] == 0) ? rise : (met[i] == 1) ? fall : (rise | fall);
            case (address)
                2'd0:    m_rd[i] = {24'd0, dnow};
                2'd2:    m_rd[i] = {24'd0, m_mask[i]};
                2'd3:    m_rd[i] = {24'd0, m_cap[i]};
                default: m_rd[i] = 32'd0;
            endcase
            clr = (wr && address == 2'd3) ? writedata[7:0] : 8'd0;
            m_cap[i] = (m_cap[i] & ~clr) | ev;
            if (wr && address == 2'd2) m_mask[i] = writedata[7:0];
            m_prev[i] = dnow;
            if (md[i] > 0) begin
                for (int b = 0; b < 8; b++) begin
                    if (m_s2[i][b] != m_deb[i][b]) begin
                        m_cnt[i][b]++;
                        if (m_cnt[i][b] == md[i]) begin
                            m_deb[i][b] = m_s2[i][b];
                            m_cnt[i][b] = 0;
                        end
                    end else begin
                        m_cnt[i][b] = 0;
                    end
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = din;
        end
    endtask

    // Called at a negedge with inputs set: one clock, then compare everything.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("rd0", rd0, m_rd[0]);
        chk("rd1", rd1, m_rd[1]);
        chk("rd2", rd2, m_rd[2]);
        chk("irq0", {31'd0, irq0}, {31'd0, |(m_cap[0] & m_mask[0])});
        chk("irq1", {31'd0, irq1}, {31'd0, |(m_cap[1] & m_mask[1])});
        chk("irq2", {31'd0, irq2}, {31'd0, |(m_cap[2] & m_mask[2])});
    endtask

    task automatic waitn(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        cycle();
        chipselect = 1'b0;
    endtask

    initial begin
        model_zero();
        @(negedge clk);
        // Reset state
        waitn(3);
        chk("rst_rd0", rd0, 32'd0);
        chk("rst_irq0", {31'd0, irq0}, 32'd0);
        rst = 1'b0;
        waitn(2);

        // Input 0x5A: data and capture timing
        in0 = 8'h5A;
        waitn(2);                       // edges k, k+1
        address = 2'd3;
        cycle();                        // k+2: shows capture before k+2
        chk("cap_k2", rd0, 32'h0);
        cycle();                        // k+3: shows capture after k+2
        chk("cap_k3", rd0, 32'h5A);
        chk("irq_nomask", {31'd0, irq0}, 32'd0);
        address = 2'd0;
        cycle();
        chk("data5a", rd0, 32'h5A);

        // Mask and clear
        in0 = 8'h00;
        bus_wr(2'd3, 32'hFF);
        bus_wr(2'd2, 32'h02);
        waitn(3);
        chk("irq_clr", {31'd0, irq0}, 32'd0);
        in0 = 8'h02;
        waitn(2);
        chk("irq_k1", {31'd0, irq0}, 32'd0);
        cycle();
        chk("irq_k2", {31'd0, irq0}, 32'd1);
        bus_wr(2'd3, 32'h02);
        chk("irq_w1c", {31'd0, irq0}, 32'd0);
        in0 = 8'h00;
        waitn(3);
        in0 = 8'h02;
        waitn(3);
        bus_wr(2'd3, 32'hFD);
        chk("irq_fd", {31'd0, irq0}, 32'd1);
        bus_rd(2'd3);
        chk("cap_fd", rd0, 32'h02);

        // Debounce: 3-cycle glitch rejected, 5-cycle pulse accepted
        bus_wr(2'd3, 32'hFF);
        address = 2'd0;
        in1 = 8'h01;
        waitn(3);
        in1 = 8'h00;
        waitn(10);
        chk("glitch_data", rd1, 32'h0);
        address = 2'd3;
        cycle();
        chk("glitch_cap", rd1, 32'h0);
        address = 2'd0;
        in1 = 8'h01;
        waitn(5);                       // edges k..k+4
        in1 = 8'h00;
        cycle();                        // k+5
        chk("deb_k5", rd1, 32'h0);
        cycle();                        // k+6
        chk("deb_k6", rd1, 32'h1);
        address = 2'd3;
        cycle();                        // k+7
        chk("deb_cap", rd1, 32'h1);
        waitn(10);

        // Set/clear collision on bit 3
        bus_wr(2'd3, 32'hFF);
        in0 = 8'h00;
        waitn(4);
        in0 = 8'h08;
        waitn(2);
        bus_wr(2'd3, 32'h08);           // W1C lands on edge k+2
        bus_rd(2'd3);
        chk("collide", rd0, 32'h08);

        // Any-edge capture
        in2 = 8'h80;
        waitn(4);
        bus_rd(2'd3);
        chk("any_rise", rd2, 32'h80);
        bus_wr(2'd3, 32'hFF);
        bus_rd(2'd3);
        chk("any_clr", rd2, 32'h0);
        in2 = 8'h00;
        waitn(4);
        bus_rd(2'd3);
        chk("any_fall", rd2, 32'h80);

        // Reserved address and writes to DATA
        bus_rd(2'd1);
        chk("rsv0", rd0, 32'h0);
        chk("rsv2", rd2, 32'h0);
        bus_wr(2'd0, 32'hFFFF_FFFF);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_rd(2'd0);
        chk("data_ro", rd0, 32'h08);

        // Random phase, including mid-run resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) in0 = 8'($urandom);
            if ($urandom_range(0, 5) == 0) in1 = 8'($urandom);
            if ($urandom_range(0, 7) == 0) in2 = 8'($urandom);
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            writedata  = $urandom;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) rst = 1'b1;
            cycle();
        end
        rst = 1'b0;
        chipselect = 1'b0;
        write_n = 1'b1;
        waitn(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
